// File: rtl/doc_hw_cmd_arb_if.sv
// Command/response channel bundle between the command requesters, the
// round-robin arbiter and the shared sensor mailbox command/response ports.
interface doc_hw_cmd_arb_if #(
    parameter int N_REQ = 2
);
    // Requester side
    logic [N_REQ-1:0]    req_i;
    logic [N_REQ-1:0]    req_valid_i;
    logic [32*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]    req_sop_i;
    logic [N_REQ-1:0]    req_eop_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [N_REQ-1:0]    grant_o;

    // Shared command sink side
    logic                cmd_valid_o;
    logic [31:0]         cmd_data_o;
    logic                cmd_sop_o;
    logic                cmd_eop_o;
    logic                cmd_ready_i;

    // Response monitoring and status
    logic                rsp_valid_i;
    logic                rsp_eop_i;
    logic [N_REQ-1:0]    rsp_owner_o;
    logic                timeout_o;
    logic                stray_rsp_o;
    logic                busy_o;

    // Arbiter view
    modport slave (
        input  req_i, req_valid_i, req_data_i, req_sop_i, req_eop_i,
        input  cmd_ready_i, rsp_valid_i, rsp_eop_i,
        output req_ready_o, grant_o,
        output cmd_valid_o, cmd_data_o, cmd_sop_o, cmd_eop_o,
        output rsp_owner_o, timeout_o, stray_rsp_o, busy_o
    );

    // Surrounding system view (requesters, command sink, response source)
    modport master (
        output req_i, req_valid_i, req_data_i, req_sop_i, req_eop_i,
        output cmd_ready_i, rsp_valid_i, rsp_eop_i,
        input  req_ready_o, grant_o,
        input  cmd_valid_o, cmd_data_o, cmd_sop_o, cmd_eop_o,
        input  rsp_owner_o, timeout_o, stray_rsp_o, busy_o
    );
endinterface

// File: rtl/doc_hw_cmd_arb.sv
// Round-robin arbiter for the shared sensor command/response channel.
// One requester owns the channel from grant until its response end-of-packet
// arrives (or the response timeout fires); its command packet is passed
// straight through to the command sink while it owns the channel.
module doc_hw_cmd_arb #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    doc_hw_cmd_arb_if.slave   bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q,  gidx_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               timeout_q, timeout_d;
    logic               stray_q,   stray_d;

    logic               found;
    logic               beat_fire;
    logic               beat_eop;
    logic [PTR_W-1:0]   ptr_after_owner;

    // Granted requester's beat handshake and end-of-packet marker.
    assign beat_fire = bus.req_valid_i[gidx_q] & bus.cmd_ready_i;
    assign beat_eop  = bus.req_eop_i[gidx_q];

    // Priority moves to the requester just after the one that finished.
    assign ptr_after_owner = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

    // State register and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            stray_q   <= stray_d;
        end
    end

    // Next-state logic: round-robin pick, packet tracking, response/timeout.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        stray_d   = bus.rsp_valid_i && (state_q != ST_WAIT_RSP);
        found     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Search upward from the pointer, wrapping at N_REQ.
                for (int k = 0; k < N_REQ; k++) begin
                    if (!found && bus.req_i[(int'(ptr_q) + k) % N_REQ]) begin
                        found   = 1'b1;
                        gidx_d  = PTR_W'((int'(ptr_q) + k) % N_REQ);
                        grant_d = N_REQ'(1) << ((int'(ptr_q) + k) % N_REQ);
                        state_d = ST_CMD;
                    end
                end
            end

            ST_CMD: begin
                // Ownership is held until the end-of-packet beat is accepted,
                // whether or not the owner keeps req_i asserted.
                if (beat_fire && beat_eop) begin
                    state_d = ST_WAIT_RSP;
                end
            end

            ST_WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.rsp_valid_i && bus.rsp_eop_i) begin
                    // A response on the final count cycle still wins.
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    ptr_d     = ptr_after_owner;
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Command pass-through mux, active only while the owner is sending.
    always_comb begin
        bus.cmd_valid_o = 1'b0;
        bus.cmd_data_o  = '0;
        bus.cmd_sop_o   = 1'b0;
        bus.cmd_eop_o   = 1'b0;
        bus.req_ready_o = '0;
        if (state_q == ST_CMD) begin
            bus.cmd_valid_o         = bus.req_valid_i[gidx_q];
            bus.cmd_data_o          = bus.req_data_i[32*int'(gidx_q) +: 32];
            bus.cmd_sop_o           = bus.req_sop_i[gidx_q];
            bus.cmd_eop_o           = bus.req_eop_i[gidx_q];
            bus.req_ready_o[gidx_q] = bus.cmd_ready_i;
        end
    end

    // Status outputs derived from the registered state.
    assign bus.grant_o     = grant_q;
    assign bus.rsp_owner_o = (state_q == ST_WAIT_RSP) ? grant_q : '0;
    assign bus.timeout_o   = timeout_q;
    assign bus.stray_rsp_o = stray_q;
    assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_doc_hw_cmd_arb.sv
// Directed bench for doc_hw_cmd_arb (N_REQ=2, TIMEOUT_CYCLES=16).
// Stimulus pushes expected command beats, timeout pulses and stray pulses
// into a queue; a monitor pops and compares whenever the DUT shows one.
module tb_doc_hw_cmd_arb;

    localparam int N_REQ          = 2;
    localparam int TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {EV_BEAT, EV_TIMEOUT, EV_STRAY} ev_kind_e;

    typedef struct {
        ev_kind_e         kind;
        logic [31:0]      data;
        logic             sop;
        logic             eop;
        logic [N_REQ-1:0] grant;
    } ev_t;

    logic clk;
    logic reset;
    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    doc_hw_cmd_arb_if #(.N_REQ(N_REQ)) bus_if ();

    doc_hw_cmd_arb #(
        .N_REQ         (N_REQ),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [N_REQ-1:0] g);
        ev_t ev;
        ev.kind = EV_BEAT; ev.data = d; ev.sop = s; ev.eop = e; ev.grant = g;
        exp_q.push_back(ev);
    endtask

    task automatic push_event(input ev_kind_e k);
        ev_t ev;
        ev.kind = k; ev.data = '0; ev.sop = 1'b0; ev.eop = 1'b0; ev.grant = '0;
        exp_q.push_back(ev);
    endtask

    task automatic drive_beat(input int r, input logic [31:0] d, input logic s, input logic e);
        bus_if.req_valid_i          = '0;
        bus_if.req_sop_i            = '0;
        bus_if.req_eop_i            = '0;
        bus_if.req_valid_i[r]       = 1'b1;
        bus_if.req_sop_i[r]         = s;
        bus_if.req_eop_i[r]         = e;
        bus_if.req_data_i[32*r +: 32] = d;
    endtask

    task automatic idle_beats();
        bus_if.req_valid_i = '0;
        bus_if.req_sop_i   = '0;
        bus_if.req_eop_i   = '0;
    endtask

    // Monitor: sample mid-cycle, compare every observable event with the queue head.
    task automatic observe(input ev_kind_e k);
        ev_t ev;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 64'(k), 64'hFF);
        end else begin
            ev = exp_q.pop_front();
            check("event_kind", 64'(k), 64'(ev.kind));
            if (ev.kind == EV_BEAT && k == EV_BEAT) begin
                check("beat_data",  64'(bus_if.cmd_data_o),  64'(ev.data));
                check("beat_sop",   64'(bus_if.cmd_sop_o),   64'(ev.sop));
                check("beat_eop",   64'(bus_if.cmd_eop_o),   64'(ev.eop));
                check("beat_grant", 64'(bus_if.grant_o),     64'(ev.grant));
                check("beat_ready", 64'(bus_if.req_ready_o), 64'(ev.grant));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus_if.cmd_valid_o && bus_if.cmd_ready_i) observe(EV_BEAT);
                if (bus_if.timeout_o)                         observe(EV_TIMEOUT);
                if (bus_if.stray_rsp_o)                       observe(EV_STRAY);
            end
        end
    end

    // Global bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus_if.req_i       = 2'b11;
        bus_if.req_valid_i = '0;
        bus_if.req_data_i  = '0;
        bus_if.req_sop_i   = '0;
        bus_if.req_eop_i   = '0;
        bus_if.cmd_ready_i = 1'b0;
        bus_if.rsp_valid_i = 1'b0;
        bus_if.rsp_eop_i   = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_grant",  64'(bus_if.grant_o),     64'h0);
        check("rst_busy",   64'(bus_if.busy_o),      64'h0);
        check("rst_cmdv",   64'(bus_if.cmd_valid_o), 64'h0);
        check("rst_ready",  64'(bus_if.req_ready_o), 64'h0);
        check("rst_tmo",    64'(bus_if.timeout_o),   64'h0);
        check("rst_stray",  64'(bus_if.stray_rsp_o), 64'h0);

        // Both request at release: requester 0 wins first
        reset = 1'b0;
        tick();
        check("first_grant", 64'(bus_if.grant_o), 64'h1);
        check("first_busy",  64'(bus_if.busy_o),  64'h1);

        // Two-beat packet from requester 0 with cmd_ready toggling
        drive_beat(0, 32'h0000_0018, 1'b1, 1'b0);
        bus_if.cmd_ready_i = 1'b0;
        #1;
        check("stall_cmdv",  64'(bus_if.cmd_valid_o), 64'h1);
        check("stall_data",  64'(bus_if.cmd_data_o),  64'h18);
        check("stall_ready", 64'(bus_if.req_ready_o), 64'h0);
        tick();
        push_beat(32'h0000_0018, 1'b1, 1'b0, 2'b01);
        bus_if.cmd_ready_i = 1'b1;
        tick();
        bus_if.req_i = 2'b10;   // owner drops req mid-packet; grant must hold
        drive_beat(0, 32'h0000_0003, 1'b0, 1'b1);
        bus_if.cmd_ready_i = 1'b0;
        tick();
        check("hold_grant", 64'(bus_if.grant_o), 64'h1);
        push_beat(32'h0000_0003, 1'b0, 1'b1, 2'b01);
        bus_if.cmd_ready_i = 1'b1;
        tick();
        idle_beats();
        bus_if.cmd_ready_i = 1'b0;
        #1;
        check("wait_owner", 64'(bus_if.rsp_owner_o), 64'h1);
        check("wait_cmdv",  64'(bus_if.cmd_valid_o), 64'h0);
        check("wait_busy",  64'(bus_if.busy_o),      64'h1);

        // Response eop returns to IDLE, then requester 1 after one idle cycle
        bus_if.rsp_valid_i = 1'b1;
        bus_if.rsp_eop_i   = 1'b1;
        tick();
        bus_if.rsp_valid_i = 1'b0;
        bus_if.rsp_eop_i   = 1'b0;
        check("rsp_idle_grant", 64'(bus_if.grant_o), 64'h0);
        check("rsp_idle_busy",  64'(bus_if.busy_o),  64'h0);
        tick();
        check("rr_grant", 64'(bus_if.grant_o), 64'h2);

        // Single-beat packet from requester 1, no response -> timeout
        drive_beat(1, 32'hA5A5_0001, 1'b1, 1'b1);
        bus_if.cmd_ready_i = 1'b1;
        push_beat(32'hA5A5_0001, 1'b1, 1'b1, 2'b10);
        tick();
        idle_beats();
        bus_if.cmd_ready_i = 1'b0;
        bus_if.req_i = 2'b00;
        push_event(EV_TIMEOUT);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        check("pre_tmo",      64'(bus_if.timeout_o), 64'h0);
        check("pre_tmo_busy", 64'(bus_if.busy_o),    64'h1);
        tick();
        check("tmo_pulse", 64'(bus_if.timeout_o), 64'h1);
        check("tmo_grant", 64'(bus_if.grant_o),   64'h0);
        check("tmo_busy",  64'(bus_if.busy_o),    64'h0);
        tick();
        check("tmo_one_cycle", 64'(bus_if.timeout_o), 64'h0);

        // Response eop on the last count cycle beats the timeout
        bus_if.req_i = 2'b01;
        tick();
        check("g0_again", 64'(bus_if.grant_o), 64'h1);
        bus_if.req_i = 2'b00;
        drive_beat(0, 32'h0000_0042, 1'b1, 1'b1);
        bus_if.cmd_ready_i = 1'b1;
        push_beat(32'h0000_0042, 1'b1, 1'b1, 2'b01);
        tick();
        idle_beats();
        bus_if.cmd_ready_i = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        bus_if.rsp_valid_i = 1'b1;
        bus_if.rsp_eop_i   = 1'b1;
        tick();
        bus_if.rsp_valid_i = 1'b0;
        bus_if.rsp_eop_i   = 1'b0;
        check("late_rsp_tmo",   64'(bus_if.timeout_o),   64'h0);
        check("late_rsp_stray", 64'(bus_if.stray_rsp_o), 64'h0);
        check("late_rsp_busy",  64'(bus_if.busy_o),      64'h0);
        tick();
        check("late_rsp_tmo2", 64'(bus_if.timeout_o), 64'h0);

        // Stray response while idle
        bus_if.rsp_valid_i = 1'b1;
        push_event(EV_STRAY);
        tick();
        bus_if.rsp_valid_i = 1'b0;
        check("stray_pulse", 64'(bus_if.stray_rsp_o), 64'h1);
        check("stray_grant", 64'(bus_if.grant_o),     64'h0);
        check("stray_busy",  64'(bus_if.busy_o),      64'h0);
        tick();
        check("stray_one_cycle", 64'(bus_if.stray_rsp_o), 64'h0);

        // Pointer now favours requester 1; reset mid-CMD clears it
        bus_if.req_i = 2'b11;
        tick();
        check("rr_ptr1_grant", 64'(bus_if.grant_o), 64'h2);
        drive_beat(1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        check("midcmd_cmdv", 64'(bus_if.cmd_valid_o), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 64'(bus_if.grant_o),     64'h0);
        check("async_busy",  64'(bus_if.busy_o),      64'h0);
        check("async_cmdv",  64'(bus_if.cmd_valid_o), 64'h0);
        check("async_data",  64'(bus_if.cmd_data_o),  64'h0);
        check("async_ready", 64'(bus_if.req_ready_o), 64'h0);
        check("async_owner", 64'(bus_if.rsp_owner_o), 64'h0);
        idle_beats();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_grant", 64'(bus_if.grant_o), 64'h1);
        bus_if.req_i = 2'b00;
        tick(); tick();

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
